ltpi_rx_frame_aligner: RTL and testbench
========================================

# ltpi_rx_frame_aligner

Receive-side frame aligner directly downstream of the LTPI PHY TX/RX. Consumes the decoded 8b/10b symbol stream (byte + K flag + decode-error flag), hunts for the K28.5 comma, assembles fixed-length frames and checks each frame's CRC-8. It declares frame alignment after a run of good frames and drops it after a run of bad ones. It presents whole frames, one per pulse, to the LTPI link/training layer above.

## Interface
- FRAME_LEN, 16: symbols per frame, including comma and CRC byte; legal range 4..32.
- LOCK_CNT, 7: consecutive good frames needed to assert `aligned`.
- UNLOCK_CNT, 3: consecutive bad frames needed to deassert `aligned`.
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sym_valid  in  1  symbol strobe from the PHY RX; symbols with `sym_valid`=0 are ignored.
- sym_data  in  8  decoded byte.
- sym_k  in  1  symbol is a K-code.
- sym_dec_err  in  1  8b/10b code or disparity violation on this symbol.
- frm_valid  out  1  one-cycle pulse: frame complete.
- frm_data  out  FRAME_LEN*8  frame bytes; byte 0 is in bits [7:0]; held until the next pulse.
- frm_crc_ok  out  1  qualifies `frm_data`; valid when `frm_valid`=1.
- aligned  out  1  frame lock status.
- clr_cnt  in  1  clears the error counters.
- crc_err_cnt  out  16  bad-frame counter, saturating.
- dec_err_cnt  out  16  `sym_dec_err` symbol counter, saturating.

## Operation
- Frame layout:
  - byte 0 is the comma (0xBC, K=1).
  - bytes 1..FRAME_LEN-2 are payload (K=0).
  - byte FRAME_LEN-1 is the CRC.
- CRC-8 definition: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR. Computed over the payload bytes only, one byte per accepted symbol.
- State HUNT:
  - Discard symbols until a comma arrives.
  - On a comma: clear the CRC, set the index to 1, go to COLLECT.
- State COLLECT:
  - Store each accepted symbol at the current index and advance the index.
  - On the CRC byte: the frame is complete; evaluate it and go to NEXT.
- State NEXT (expecting the next comma):
  - Comma: go to COLLECT.
  - Any other symbol: counts as a bad frame event; go to HUNT.
- A frame is bad if any of these hold:
  - CRC mismatch.
  - Any payload or CRC symbol has K=1.
  - Any symbol of the frame has `sym_dec_err`=1.
- Comma inside COLLECT:
  - The current frame is aborted; no `frm_valid` pulse is produced for it.
  - The abort counts as a bad frame event.
  - Collection restarts at index 1 from that comma.
- Lock counters:
  - Good frame: reset the bad-run count; increment the good-run count, saturating at LOCK_CNT; when it reaches LOCK_CNT, `aligned`←1.
  - Bad event: reset the good-run count; increment the bad-run count; when it reaches UNLOCK_CNT, `aligned`←0.
- When not aligned, any bad event returns the FSM to HUNT. When aligned, the FSM keeps framing on the FRAME_LEN grid; only a missing comma forces HUNT.
- `frm_valid` pulses for every completed frame, aligned or not. Consumers gate on `aligned` and `frm_crc_ok`.

## Timing
- Reset state:
  - FSM in HUNT; `frm_valid`=0, `frm_crc_ok`=0, `aligned`=0.
  - `frm_data`=0; both counters 0; run counts 0.
- Latency: `frm_valid`, `frm_crc_ok` and the updated `frm_data` register 1 cycle after the CRC symbol is accepted.
- `aligned` update:
  - Rises in the same cycle as the `frm_valid` of the LOCK_CNT-th good frame.
  - Falls 1 cycle after the symbol that produces the UNLOCK_CNT-th bad event.
- Gaps (`sym_valid`=0) may appear anywhere and only stall progress. There is no timeout.
- A comma in NEXT on the cycle after a CRC symbol is the normal back-to-back case: zero bubbles between frames.
- Counter saturation: both counters hold at 0xFFFF.
- `clr_cnt` wins over a simultaneous increment; the result is 0.
- `reset_n` low mid-frame:
  - The partial frame is discarded and no pulse is produced.
  - All state returns to reset values on the next edge.

## Configuration
- Macro: `LTPI_RX_FRAME_CNT_EN`.
- Defined: `crc_err_cnt` and `dec_err_cnt` are implemented as above.
- Undefined: both outputs are tied to 0, the counter logic is removed, and `clr_cnt` is ignored.
- Framing and lock behaviour are identical in both builds.

## Test plan
- Ideal link: after reset, send 8 frames each of 0xBC(K), fourteen 0x00 and CRC 0x00 → 8 `frm_valid` pulses, each 1 cycle after the CRC byte, all with `frm_crc_ok`=1; `aligned` rises with the 7th pulse; `crc_err_cnt`=0.
- CRC corruption while locked: send 3 frames with CRC byte 0xFF → `frm_crc_ok`=0 on each; `aligned` falls after the 3rd; `crc_err_cnt`=3.
- Misalignment: send 5 idle 0x00 bytes before the first comma → the 5 bytes are discarded, the first pulse occurs 16 symbols after the comma, and `frm_data[7:0]`=0xBC.
- Early comma: a comma at index 9 of an unaligned frame → no pulse for the aborted frame; the next pulse comes 16 symbols after the second comma; `crc_err_cnt`=1.
- Decode error and gaps: `sym_dec_err`=1 on byte 4, with random `sym_valid` gaps throughout → that frame has `frm_crc_ok`=0; `dec_err_cnt`=1; frame spacing is unchanged apart from the gap stalls.
- Counter edges: force 0xFFFF errors → the counter holds at 0xFFFF; `clr_cnt` on the same cycle as a bad frame → 0; with the macro undefined, both counters read 0 throughout.

Source files
------------

// File: rtl/ltpi_rx_frame_aligner.sv
// ---------------------------------------------------------------------------
// ltpi_rx_frame_aligner
//
// Receive-side frame aligner between the LTPI PHY decoder and the link /
// training layer. It hunts for the K28.5 comma, collects FRAME_LEN-symbol
// frames, checks the CRC-8 (poly 0x07, init 0, MSB-first, over the payload
// bytes only) and tracks frame lock from runs of good and bad frames.
//
// Handshake: sym_valid is a pure strobe. A symbol is consumed on every
// rising edge where sym_valid=1 and there is no backpressure. frm_valid is a
// one-cycle pulse with no ready; frm_data/frm_crc_ok hold until the next pulse.
//
// Ports
//   clk, reset_n               clock, synchronous active-low reset
//   sym_valid/sym_data/sym_k/  decoded symbol stream from the PHY RX
//   sym_dec_err
//   frm_valid/frm_data/        completed frame (byte 0 in bits [7:0])
//   frm_crc_ok
//   aligned                    frame lock status
//   clr_cnt                    clears both error counters
//   crc_err_cnt, dec_err_cnt   saturating bad-frame / decode-error counters
//
// Build option: define LTPI_RX_FRAME_CNT_EN to implement the two error
// counters. Without it both counter outputs read 0 and clr_cnt is ignored.
// ---------------------------------------------------------------------------
module ltpi_rx_frame_aligner #(
    parameter int FRAME_LEN  = 16,
    parameter int LOCK_CNT   = 7,
    parameter int UNLOCK_CNT = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sym_valid,
    input  logic [7:0]             sym_data,
    input  logic                   sym_k,
    input  logic                   sym_dec_err,
    output logic                   frm_valid,
    output logic [FRAME_LEN*8-1:0] frm_data,
    output logic                   frm_crc_ok,
    output logic                   aligned,
    input  logic                   clr_cnt,
    output logic [15:0]            crc_err_cnt,
    output logic [15:0]            dec_err_cnt
);

    localparam int DW     = FRAME_LEN * 8;
    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(UNLOCK_CNT);
    localparam logic [7:0]        COMMA    = 8'hBC;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_NEXT    = 2'd2
    } state_e;

    // One CRC-8 byte update, poly 0x07, MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          crc_q, crc_d;
    logic                fbad_q, fbad_d;
    logic [DW-1:0]       buf_q, buf_d;
    logic                frm_valid_q, frm_valid_d;
    logic                frm_crc_ok_q, frm_crc_ok_d;
    logic [DW-1:0]       frm_data_q, frm_data_d;
    logic                aligned_q, aligned_d;
    logic [GOOD_W-1:0]   good_run_q, good_run_d;
    logic [BAD_W-1:0]    bad_run_q, bad_run_d;

    logic                is_comma;
    logic                fbad_cur;
    logic                frame_ok;
    logic                good_evt;
    logic                bad_evt;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        crc_d        = crc_q;
        fbad_d       = fbad_q;
        buf_d        = buf_q;
        frm_valid_d  = 1'b0;
        frm_crc_ok_d = frm_crc_ok_q;
        frm_data_d   = frm_data_q;
        aligned_d    = aligned_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        good_evt     = 1'b0;
        bad_evt      = 1'b0;
        frame_ok     = 1'b0;
        fbad_cur     = fbad_q | sym_k | sym_dec_err;
        is_comma     = sym_k && (sym_data == COMMA);

        if (sym_valid) begin
            // A comma always (re)starts collection. Inside COLLECT it also
            // aborts the partial frame, which counts as a bad event.
            if (is_comma) begin
                if (state_q == ST_COLLECT) begin
                    bad_evt = 1'b1;
                end
                state_d    = ST_COLLECT;
                idx_d      = IDX_W'(1);
                crc_d      = 8'h00;
                fbad_d     = sym_dec_err;
                buf_d[7:0] = COMMA;
            end else begin
                case (state_q)
                    ST_COLLECT: begin
                        buf_d[{idx_q, 3'b000} +: 8] = sym_data;
                        if (idx_q == LAST_IDX) begin
                            frame_ok     = !fbad_cur && (crc_q == sym_data);
                            frm_valid_d  = 1'b1;
                            frm_crc_ok_d = frame_ok;
                            frm_data_d   = buf_d;
                            good_evt     = frame_ok;
                            bad_evt      = !frame_ok;
                            // Unlocked: a bad frame sends us hunting again.
                            // Locked: stay on the grid and expect the comma.
                            state_d      = (frame_ok || aligned_q) ? ST_NEXT : ST_HUNT;
                        end else begin
                            crc_d  = crc8_step(crc_q, sym_data);
                            idx_d  = idx_q + 1'b1;
                            fbad_d = fbad_cur;
                        end
                    end
                    ST_NEXT: begin
                        // Missing comma on the grid.
                        bad_evt = 1'b1;
                        state_d = ST_HUNT;
                    end
                    default: begin
                        state_d = ST_HUNT;
                    end
                endcase
            end
        end

        if (good_evt) begin
            bad_run_d = '0;
            if (good_run_q != GOOD_MAX) begin
                good_run_d = good_run_q + 1'b1;
            end
            if (good_run_d == GOOD_MAX) begin
                aligned_d = 1'b1;
            end
        end else if (bad_evt) begin
            good_run_d = '0;
            if (bad_run_q != BAD_MAX) begin
                bad_run_d = bad_run_q + 1'b1;
            end
            if (bad_run_d == BAD_MAX) begin
                aligned_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            idx_q        <= '0;
            crc_q        <= 8'h00;
            fbad_q       <= 1'b0;
            buf_q        <= '0;
            frm_valid_q  <= 1'b0;
            frm_crc_ok_q <= 1'b0;
            frm_data_q   <= '0;
            aligned_q    <= 1'b0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            crc_q        <= crc_d;
            fbad_q       <= fbad_d;
            buf_q        <= buf_d;
            frm_valid_q  <= frm_valid_d;
            frm_crc_ok_q <= frm_crc_ok_d;
            frm_data_q   <= frm_data_d;
            aligned_q    <= aligned_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
        end
    end

    assign frm_valid  = frm_valid_q;
    assign frm_crc_ok = frm_crc_ok_q;
    assign frm_data   = frm_data_q;
    assign aligned    = aligned_q;

`ifdef LTPI_RX_FRAME_CNT_EN
    logic [15:0] crc_err_cnt_q, crc_err_cnt_d;
    logic [15:0] dec_err_cnt_q, dec_err_cnt_d;

    // Clear has priority over a same-cycle increment.
    always_comb begin
        crc_err_cnt_d = crc_err_cnt_q;
        dec_err_cnt_d = dec_err_cnt_q;
        if (clr_cnt) begin
            crc_err_cnt_d = 16'h0000;
            dec_err_cnt_d = 16'h0000;
        end else begin
            if (bad_evt && (crc_err_cnt_q != 16'hFFFF)) begin
                crc_err_cnt_d = crc_err_cnt_q + 16'd1;
            end
            if (sym_valid && sym_dec_err && (dec_err_cnt_q != 16'hFFFF)) begin
                dec_err_cnt_d = dec_err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            crc_err_cnt_q <= 16'h0000;
            dec_err_cnt_q <= 16'h0000;
        end else begin
            crc_err_cnt_q <= crc_err_cnt_d;
            dec_err_cnt_q <= dec_err_cnt_d;
        end
    end

    assign crc_err_cnt = crc_err_cnt_q;
    assign dec_err_cnt = dec_err_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign crc_err_cnt    = 16'h0000;
    assign dec_err_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_ltpi_rx_frame_aligner.sv
// ---------------------------------------------------------------------------
// tb_ltpi_rx_frame_aligner
//
// Drives directed and randomized symbol streams into ltpi_rx_frame_aligner
// and compares every cycle against a frame-level reference model that keeps
// the current frame in a queue and evaluates it when it is complete.
// ---------------------------------------------------------------------------
module tb_ltpi_rx_frame_aligner;

    localparam int FRAME_LEN  = 16;
    localparam int LOCK_CNT   = 7;
    localparam int UNLOCK_CNT = 3;
    localparam int DW         = FRAME_LEN * 8;
    localparam int W          = DW + 1;
`ifdef LTPI_RX_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          reset_n;
    logic          sym_valid;
    logic [7:0]    sym_data;
    logic          sym_k;
    logic          sym_dec_err;
    logic          clr_cnt;
    logic          frm_valid;
    logic [DW-1:0] frm_data;
    logic          frm_crc_ok;
    logic          aligned;
    logic [15:0]   crc_err_cnt;
    logic [15:0]   dec_err_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    ltpi_rx_frame_aligner #(
        .FRAME_LEN (FRAME_LEN),
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_k      (sym_k),
        .sym_dec_err(sym_dec_err),
        .frm_valid  (frm_valid),
        .frm_data   (frm_data),
        .frm_crc_ok (frm_crc_ok),
        .aligned    (aligned),
        .clr_cnt    (clr_cnt),
        .crc_err_cnt(crc_err_cnt),
        .dec_err_cnt(dec_err_cnt)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp   = 0;
    int n_bad   = 0;
    int n_pulse = 0;
    bit chk_en  = 1'b0;
    bit drv_rst = 1'b0;
    bit force_clr = 1'b0;
    int gap_pct = 0;
    int clr_pct = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]    fq[$];          // symbols of the frame being collected
    bit            m_in_frame;
    bit            m_want_comma;
    bit            m_fbad;
    int            m_good;
    int            m_bad;
    bit            m_aligned;
    int            m_crc_cnt;
    int            m_dec_cnt;
    logic [DW-1:0] m_data;
    bit            exp_valid;
    logic [W-1:0]  exp_q[$];       // {crc_ok, frame} per expected pulse

    // Bit-serial CRC-8 over payload bytes 1..FRAME_LEN-2.
    function automatic logic [7:0] ref_crc(input logic [DW-1:0] fr);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 1; i <= FRAME_LEN - 2; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ fr[i*8 + b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic model_step(input bit rst_n, input bit v, input logic [7:0] d,
                              input bit k, input bit e, input bit clr);
        bit            comma;
        bit            good_evt;
        bit            bad_evt;
        bit            ok;
        logic [DW-1:0] fr;
        exp_valid = 1'b0;
        if (!rst_n) begin
            fq.delete();
            m_in_frame   = 1'b0;
            m_want_comma = 1'b0;
            m_fbad       = 1'b0;
            m_good       = 0;
            m_bad        = 0;
            m_aligned    = 1'b0;
            m_crc_cnt    = 0;
            m_dec_cnt    = 0;
            m_data       = '0;
            return;
        end
        good_evt = 1'b0;
        bad_evt  = 1'b0;
        if (v) begin
            comma = k && (d == 8'hBC);
            if (comma) begin
                if (m_in_frame) bad_evt = 1'b1;
                fq.delete();
                fq.push_back(8'hBC);
                m_in_frame   = 1'b1;
                m_want_comma = 1'b0;
                m_fbad       = e;
            end else if (m_in_frame) begin
                fq.push_back(d);
                m_fbad = m_fbad | k | e;
                if (fq.size() == FRAME_LEN) begin
                    fr = '0;
                    for (int i = 0; i < FRAME_LEN; i++) fr[i*8 +: 8] = fq[i];
                    ok = !m_fbad && (ref_crc(fr) == fq[FRAME_LEN-1]);
                    exp_valid = 1'b1;
                    m_data    = fr;
                    exp_q.push_back({ok, fr});
                    m_in_frame   = 1'b0;
                    m_want_comma = ok || m_aligned;
                    good_evt     = ok;
                    bad_evt      = !ok;
                end
            end else if (m_want_comma) begin
                bad_evt      = 1'b1;
                m_want_comma = 1'b0;
            end
        end
        if (good_evt) begin
            m_bad = 0;
            if (m_good < LOCK_CNT) m_good++;
            if (m_good == LOCK_CNT) m_aligned = 1'b1;
        end
        if (bad_evt) begin
            m_good = 0;
            m_bad++;
            if (m_bad >= UNLOCK_CNT) m_aligned = 1'b0;
        end
        if (CNT_EN) begin
            if (clr) begin
                m_crc_cnt = 0;
                m_dec_cnt = 0;
            end else begin
                if (bad_evt && m_crc_cnt < 65535) m_crc_cnt++;
                if (v && e && m_dec_cnt < 65535) m_dec_cnt++;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        logic [W-1:0] ent;
        check_val("frm_valid", frm_valid, exp_valid);
        check_val("aligned", aligned, m_aligned);
        check_val("frm_data", frm_data, m_data);
        check_val("crc_err_cnt", crc_err_cnt, DW'(m_crc_cnt));
        check_val("dec_err_cnt", dec_err_cnt, DW'(m_dec_cnt));
        if (frm_valid === 1'b1) begin
            n_pulse++;
            check_val("frm_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                check_val("frm_crc_ok", frm_crc_ok, ent[W-1]);
                check_val("frm_content", frm_data, ent[DW-1:0]);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit v, input logic [7:0] d, input bit k, input bit e);
        bit clr;
        @(negedge clk);
        if (chk_en) check_outputs();
        clr         = force_clr || ($urandom_range(0, 99) < clr_pct);
        reset_n     = drv_rst;
        clr_cnt     = clr;
        sym_valid   = v;
        sym_data    = d;
        sym_k       = k;
        sym_dec_err = e;
        model_step(drv_rst, v, d, k, e, clr);
    endtask

    task automatic sym(input logic [7:0] d, input bit k, input bit e);
        while ($urandom_range(0, 99) < gap_pct) begin
            cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
        end
        cyc(1'b1, d, k, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drv_rst = 1'b0;
        idle(2);
        chk_en  = 1'b1;
        drv_rst = 1'b1;
    endtask

    // kind: 0 good, 1 CRC flipped, 2 dec_err at idx, 3 K-code at idx,
    //       4 truncated to idx symbols, 5 comma replaced by data byte
    task automatic send_frame(input int kind, input int idx, input bit zero_pl, input bit clr_last);
        logic [DW-1:0]        fr;
        logic [FRAME_LEN-1:0] kv;
        logic [FRAME_LEN-1:0] ev;
        int                   n;
        fr = '0;
        kv = '0;
        ev = '0;
        n  = FRAME_LEN;
        fr[7:0] = 8'hBC;
        kv[0]   = 1'b1;
        for (int i = 1; i < FRAME_LEN - 1; i++) fr[i*8 +: 8] = zero_pl ? 8'h00 : 8'($urandom);
        fr[(FRAME_LEN-1)*8 +: 8] = ref_crc(fr);
        case (kind)
            1: fr[(FRAME_LEN-1)*8 +: 8] = fr[(FRAME_LEN-1)*8 +: 8] ^ 8'hFF;
            2: ev[idx] = 1'b1;
            3: begin
                fr[idx*8 +: 8] = 8'h1C;
                kv[idx]        = 1'b1;
            end
            4: n = idx;
            5: begin
                fr[7:0] = 8'($urandom_range(0, 8'hBB));
                kv[0]   = 1'b0;
            end
            default: ;
        endcase
        for (int i = 0; i < n; i++) begin
            force_clr = clr_last && (i == FRAME_LEN - 1);
            sym(fr[i*8 +: 8], kv[i], ev[i]);
        end
        force_clr = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p0;
        int r;
        reset_n = 1'b0; sym_valid = 1'b0; sym_data = 8'h00;
        sym_k = 1'b0; sym_dec_err = 1'b0; clr_cnt = 1'b0;

        // reset state
        do_reset();
        @(negedge clk);
        check_val("rst_frm_valid", frm_valid, 1'b0);
        check_val("rst_crc_ok", frm_crc_ok, 1'b0);
        check_val("rst_aligned", aligned, 1'b0);
        check_val("rst_frm_data", frm_data, '0);

        // ideal link: 8 zero frames back to back
        p0 = n_pulse;
        for (int i = 0; i < 8; i++) send_frame(0, 0, 1'b1, 1'b0);
        idle(1);
        check_val("ideal_pulses", n_pulse - p0, 8);
        check_val("ideal_aligned", aligned, 1'b1);
        check_val("ideal_crc_cnt", crc_err_cnt, 0);

        // CRC corruption while locked
        for (int i = 0; i < 3; i++) send_frame(1, 0, 1'b1, 1'b0);
        idle(1);
        check_val("crc_unlock", aligned, 1'b0);
        check_val("crc_cnt3", crc_err_cnt, CNT_EN ? 3 : 0);

        // misalignment: idle data before the first comma
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);
        p0 = n_pulse;
        send_frame(0, 0, 1'b0, 1'b0);
        idle(1);
        check_val("misalign_pulses", n_pulse - p0, 1);
        check_val("misalign_byte0", frm_data[7:0], 8'hBC);

        // early comma at index 9
        do_reset();
        p0 = n_pulse;
        send_frame(4, 9, 1'b0, 1'b0);
        send_frame(0, 0, 1'b0, 1'b0);
        idle(1);
        check_val("early_pulses", n_pulse - p0, 1);
        check_val("early_crc_cnt", crc_err_cnt, CNT_EN ? 1 : 0);

        // decode error on byte 4 with gaps
        do_reset();
        gap_pct = 30;
        send_frame(0, 0, 1'b0, 1'b0);
        send_frame(2, 4, 1'b0, 1'b0);
        send_frame(0, 0, 1'b0, 1'b0);
        gap_pct = 0;
        idle(1);
        check_val("decerr_cnt", dec_err_cnt, CNT_EN ? 1 : 0);

        // reset in the middle of a frame
        do_reset();
        p0 = n_pulse;
        send_frame(0, 0, 1'b0, 1'b0);
        send_frame(4, 8, 1'b0, 1'b0);
        do_reset();
        send_frame(4, 8, 1'b0, 1'b0);
        idle(4);
        check_val("midrst_pulses", n_pulse - p0, 1);

        // clear on the same cycle as a bad frame
        do_reset();
        send_frame(1, 0, 1'b0, 1'b0);
        send_frame(1, 0, 1'b0, 1'b1);
        idle(1);
        check_val("clr_wins", crc_err_cnt, 0);

        // randomized traffic
        do_reset();
        clr_pct = 2;
        for (int f = 0; f < 300; f++) begin
            gap_pct = $urandom_range(0, 25);
            r = $urandom_range(0, 9);
            if (r <= 5)      send_frame(0, 0, 1'b0, 1'b0);
            else if (r == 6) send_frame(1, 0, 1'b0, 1'b0);
            else if (r == 7) send_frame(2, $urandom_range(0, FRAME_LEN - 1), 1'b0, 1'b0);
            else if (r == 8) send_frame(($urandom_range(0, 1) == 0) ? 3 : 4, $urandom_range(1, FRAME_LEN - 1), 1'b0, 1'b0);
            else             send_frame(5, 0, 1'b0, 1'b0);
        end
        gap_pct = 0;
        clr_pct = 0;
        idle(2);

`ifdef LTPI_RX_FRAME_CNT_EN
        // counter saturation
        do_reset();
        for (int i = 0; i < 65540; i++) cyc(1'b1, 8'h00, 1'b0, 1'b1);
        idle(1);
        check_val("dec_sat", dec_err_cnt, 16'hFFFF);
        force_clr = 1'b1;
        idle(1);
        force_clr = 1'b0;
        idle(1);
        check_val("dec_clr", dec_err_cnt, 0);
`endif

        idle(3);
        check_val("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
